// File: rtl/mode_select_controller.sv
// mode_select_controller
//   Turns debounced pushbutton levels into filter-mode selection and commit
//   requests for the image pipeline. next/prev step a pending mode index
//   (with wrap-around). apply requests a commit of that index. The commit is
//   offered to the pipeline only after a frame boundary, over a valid/ready
//   handshake.
//
//   Optional feature macro: HOLD_REPEAT_EN
//     defined   : holding next/prev auto-repeats after a delay, then at a fixed rate
//     undefined : one step per button rise; no hold counter exists
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   btn_next/btn_prev   debounced levels, step pending mode up/down
//   btn_apply           debounced level, request commit of pending mode
//   frame_start         one-cycle pulse at start of each frame
//   pending_mode        user's current selection (LED display)
//   active_mode         mode last accepted by the pipeline
//   cfg_valid/cfg_mode  commit offer to the pipeline
//   cfg_ready           pipeline accepts cfg_mode when high with cfg_valid
//   busy                high from an accepted apply until the handshake completes
//   dbg_step_state      step FSM state (0 when auto-repeat is compiled out)
//   dbg_commit_state    commit FSM state
//
// Handshake: cfg_mode is transferred on a cycle where cfg_valid && cfg_ready
// are both high. Once raised, cfg_valid and cfg_mode stay stable until that
// cycle, and cfg_valid drops on the following cycle.
module mode_select_controller #(
   parameter int NUM_MODES       = 8,
   parameter int MODE_BITS       = 3,
   parameter int CLOCK_FREQ_HZ   = 100_000_000,
   parameter int REPEAT_DELAY_MS = 500,
   parameter int REPEAT_RATE_MS  = 100
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 btn_next,
   input  logic                 btn_prev,
   input  logic                 btn_apply,
   input  logic                 frame_start,
   output logic [MODE_BITS-1:0] pending_mode,
   output logic [MODE_BITS-1:0] active_mode,
   output logic                 cfg_valid,
   output logic [MODE_BITS-1:0] cfg_mode,
   input  logic                 cfg_ready,
   output logic                 busy,
   output logic [1:0]           dbg_step_state,
   output logic [1:0]           dbg_commit_state
);

   localparam logic [MODE_BITS-1:0] LAST_MODE = MODE_BITS'(NUM_MODES - 1);

   // ---------------- button edge detection ----------------
   // Edge registers reset to 0, so a button held through reset is seen as a rise.
   logic r_next_d, r_prev_d, r_apply_d;
   logic w_rise_next, w_rise_prev, w_rise_apply;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_next_d  <= 1'b0;
         r_prev_d  <= 1'b0;
         r_apply_d <= 1'b0;
      end else begin
         r_next_d  <= btn_next;
         r_prev_d  <= btn_prev;
         r_apply_d <= btn_apply;
      end
   end

   assign w_rise_next  = btn_next  & ~r_next_d;
   assign w_rise_prev  = btn_prev  & ~r_prev_d;
   assign w_rise_apply = btn_apply & ~r_apply_d;

   // ---------------- pending mode stepping ----------------
   function automatic logic [MODE_BITS-1:0] f_step(input logic [MODE_BITS-1:0] m,
                                                  input logic up);
      if (up) f_step = (m == LAST_MODE) ? '0 : m + MODE_BITS'(1);
      else    f_step = (m == '0) ? LAST_MODE : m - MODE_BITS'(1);
   endfunction

   logic                 w_step_en;
   logic                 w_step_up;
   logic [MODE_BITS-1:0] r_pending;

`ifdef HOLD_REPEAT_EN
   localparam int DELAY_TICKS = REPEAT_DELAY_MS * (CLOCK_FREQ_HZ / 1000);
   localparam int RATE_TICKS  = REPEAT_RATE_MS * (CLOCK_FREQ_HZ / 1000);
   localparam int MAX_TICKS   = (DELAY_TICKS > RATE_TICKS) ? DELAY_TICKS : RATE_TICKS;
   localparam int CNT_W       = $clog2(MAX_TICKS) + 1;
   localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(DELAY_TICKS - 1);
   localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(RATE_TICKS - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, HOLD_DELAY = 2'd1, HOLD_REPEAT = 2'd2} step_state_t;

   step_state_t      r_sstate, w_sstate_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic             r_dir_up, w_dir_up_nxt;
   logic             w_held, w_opp;

   // Level of the button that started the hold, and of the opposite one.
   assign w_held = r_dir_up ? btn_next : btn_prev;
   assign w_opp  = r_dir_up ? btn_prev : btn_next;

   always_comb begin
      w_sstate_nxt = r_sstate;
      w_cnt_nxt    = r_cnt;
      w_dir_up_nxt = r_dir_up;
      w_step_en    = 1'b0;
      w_step_up    = r_dir_up;
      case (r_sstate)
         IDLE: begin
            // A simultaneous rise of both buttons is ambiguous and ignored.
            if (w_rise_next ^ w_rise_prev) begin
               w_step_en    = 1'b1;
               w_step_up    = w_rise_next;
               w_dir_up_nxt = w_rise_next;
               w_cnt_nxt    = '0;
               w_sstate_nxt = HOLD_DELAY;
            end
         end
         HOLD_DELAY, HOLD_REPEAT: begin
            if (!w_held || w_opp) begin
               w_sstate_nxt = IDLE;
            end else if (r_cnt == ((r_sstate == HOLD_DELAY) ? DELAY_LAST : RATE_LAST)) begin
               w_step_en    = 1'b1;
               w_cnt_nxt    = '0;
               w_sstate_nxt = HOLD_REPEAT;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         default: w_sstate_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sstate <= IDLE;
         r_cnt    <= '0;
         r_dir_up <= 1'b0;
      end else begin
         r_sstate <= w_sstate_nxt;
         r_cnt    <= w_cnt_nxt;
         r_dir_up <= w_dir_up_nxt;
      end
   end

   assign dbg_step_state = r_sstate;
`else
   // Without auto-repeat every single-button rise is exactly one step.
   assign w_step_en      = w_rise_next ^ w_rise_prev;
   assign w_step_up      = w_rise_next;
   assign dbg_step_state = 2'd0;
`endif

   always_ff @(posedge clk) begin
      if (reset)          r_pending <= '0;
      else if (w_step_en) r_pending <= f_step(r_pending, w_step_up);
   end

   // ---------------- commit FSM ----------------
   typedef enum logic [1:0] {C_IDLE = 2'd0, C_WAIT_FRAME = 2'd1, C_OFFER = 2'd2} commit_state_t;

   commit_state_t        r_cstate, w_cstate_nxt;
   logic [MODE_BITS-1:0] r_cfg_mode, w_cfg_mode_nxt;
   logic [MODE_BITS-1:0] r_active, w_active_nxt;

   always_comb begin
      w_cstate_nxt   = r_cstate;
      w_cfg_mode_nxt = r_cfg_mode;
      w_active_nxt   = r_active;
      case (r_cstate)
         C_IDLE: begin
            // Re-applying the mode already active is a no-op.
            if (w_rise_apply && (r_pending != r_active)) begin
               w_cfg_mode_nxt = r_pending;
               w_cstate_nxt   = C_WAIT_FRAME;
            end
         end
         C_WAIT_FRAME: begin
            // A fresh apply wins over a coincident frame_start: the latest
            // selection is kept and offered at the next frame instead.
            if (w_rise_apply) w_cfg_mode_nxt = r_pending;
            else if (frame_start) w_cstate_nxt = C_OFFER;
         end
         C_OFFER: begin
            if (cfg_ready) begin
               w_active_nxt = r_cfg_mode;
               w_cstate_nxt = C_IDLE;
            end
         end
         default: w_cstate_nxt = C_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cstate   <= C_IDLE;
         r_cfg_mode <= '0;
         r_active   <= '0;
      end else begin
         r_cstate   <= w_cstate_nxt;
         r_cfg_mode <= w_cfg_mode_nxt;
         r_active   <= w_active_nxt;
      end
   end

   assign pending_mode     = r_pending;
   assign active_mode      = r_active;
   assign cfg_mode         = r_cfg_mode;
   assign cfg_valid        = (r_cstate == C_OFFER);
   assign busy             = (r_cstate != C_IDLE);
   assign dbg_commit_state = r_cstate;

endmodule

// File: tb/tb_mode_select_controller.sv
// tb_mode_select_controller
//   Directed scenarios with literal expectations, followed by a randomized
//   phase. A behavioural model tracks the expected outputs from the button
//   rules (hold length, wrap arithmetic, commit phase) and is compared
//   against the DUT on every falling edge once the first reset is applied.
module tb_mode_select_controller;

   localparam int NM    = 6;
   localparam int MB    = 3;
   localparam int DELAY = 5;   // 5 ms at 1 kHz
   localparam int RATE  = 2;   // 2 ms at 1 kHz

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          btn_next = 1'b0, btn_prev = 1'b0, btn_apply = 1'b0;
   logic          frame_start = 1'b0, cfg_ready = 1'b0;
   logic [MB-1:0] pending_mode, active_mode, cfg_mode;
   logic          cfg_valid, busy;
   logic [1:0]    dbg_step_state, dbg_commit_state;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   always #5 clk = ~clk;

   mode_select_controller #(
      .NUM_MODES(NM), .MODE_BITS(MB), .CLOCK_FREQ_HZ(1000),
      .REPEAT_DELAY_MS(5), .REPEAT_RATE_MS(2)
   ) dut (
      .clk(clk), .reset(reset),
      .btn_next(btn_next), .btn_prev(btn_prev), .btn_apply(btn_apply),
      .frame_start(frame_start),
      .pending_mode(pending_mode), .active_mode(active_mode),
      .cfg_valid(cfg_valid), .cfg_mode(cfg_mode), .cfg_ready(cfg_ready),
      .busy(busy),
      .dbg_step_state(dbg_step_state), .dbg_commit_state(dbg_commit_state)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int m_pend = 0, m_act = 0, m_cfg = 0;
   bit m_valid = 0, m_busy = 0;
   bit m_pn = 0, m_pp = 0, m_pa = 0;
   bit m_hold = 0, m_up = 0;
   int m_k = 0;   // edges elapsed since the rise that started the current hold

   function automatic int step_mode(input int v, input bit up);
      return up ? (v + 1) % NM : (v + NM - 1) % NM;
   endfunction

   always @(posedge clk) begin : model
      bit rn, rp, ra, lvl, opp;
      int old_pend;
      if (reset) begin
         m_pend = 0; m_act = 0; m_cfg = 0; m_valid = 0; m_busy = 0;
         m_pn = 0; m_pp = 0; m_pa = 0; m_hold = 0; m_up = 0; m_k = 0;
      end else begin
         rn = btn_next && !m_pn;
         rp = btn_prev && !m_pp;
         ra = btn_apply && !m_pa;
         old_pend = m_pend;
         // commit side uses the selection as it stood before this edge
         if (!m_busy) begin
            if (ra && old_pend != m_act) begin m_cfg = old_pend; m_busy = 1; end
         end else if (!m_valid) begin
            if (ra) m_cfg = old_pend;
            else if (frame_start) m_valid = 1;
         end else if (cfg_ready) begin
            m_act = m_cfg; m_valid = 0; m_busy = 0;
         end
         // step side
         if (m_hold) begin
            lvl = m_up ? btn_next : btn_prev;
            opp = m_up ? btn_prev : btn_next;
            if (!lvl || opp) m_hold = 0;
            else begin
               m_k++;
               if (m_k == DELAY || (m_k > DELAY && (m_k - DELAY) % RATE == 0))
                  m_pend = step_mode(m_pend, m_up);
            end
         end else if (rn != rp) begin
            m_pend = step_mode(m_pend, rn);
`ifdef HOLD_REPEAT_EN
            m_hold = 1; m_up = rn; m_k = 0;
`endif
         end
         m_pn = btn_next; m_pp = btn_prev; m_pa = btn_apply;
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         check("cyc_pending", 32'(pending_mode), m_pend);
         check("cyc_active",  32'(active_mode),  m_act);
         check("cyc_cfg_mode", 32'(cfg_mode),    m_cfg);
         check("cyc_cfg_valid", 32'(cfg_valid),  32'(m_valid));
         check("cyc_busy", 32'(busy), 32'(m_busy));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      chk_en = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic pulse_next();
      btn_next = 1'b1; tick(); btn_next = 1'b0; tick();
   endtask

   task automatic pulse_prev();
      btn_prev = 1'b1; tick(); btn_prev = 1'b0; tick();
   endtask

   int exp1[7] = '{1, 2, 3, 4, 5, 0, 1};
`ifdef HOLD_REPEAT_EN
   int exp3[12] = '{1, 1, 1, 1, 1, 2, 2, 3, 3, 4, 4, 5};
`else
   int exp3[12] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
`endif

   initial begin
      // 1: single-step wrap
      do_reset();
      check("s1_reset_pend", 32'(pending_mode), 0);
      check("s1_reset_busy", 32'(busy), 0);
      for (int i = 0; i < 7; i++) begin
         btn_next = 1'b1; tick();
         check("s1_pend", 32'(pending_mode), exp1[i]);
         btn_next = 1'b0; tick();
      end
      check("s1_model_pend", m_pend, 1);
      check("s1_active", 32'(active_mode), 0);
      check("s1_valid", 32'(cfg_valid), 0);

      // 2: prev wrap and simultaneous rise
      do_reset();
      btn_prev = 1'b1; tick();
      check("s2_prev_wrap", 32'(pending_mode), 5);
      btn_prev = 1'b0; tick();
      btn_next = 1'b1; btn_prev = 1'b1; tick();
      check("s2_both_rise", 32'(pending_mode), 5);
      tick();
      check("s2_both_held", 32'(pending_mode), 5);
      btn_next = 1'b0; btn_prev = 1'b0; tick();

      // 3: hold-to-repeat
      do_reset();
      btn_next = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         check("s3_hold_pend", 32'(pending_mode), exp3[i]);
      end
      btn_next = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      check("s3_release_pend", 32'(pending_mode), exp3[11]);
      check("s3_model_pend", m_pend, exp3[11]);

      // 4: commit with back-pressure
      do_reset();
      pulse_next(); pulse_next(); pulse_next();
      check("s4_pend3", 32'(pending_mode), 3);
      btn_apply = 1'b1; tick();
      check("s4_busy", 32'(busy), 1);
      check("s4_valid_wait", 32'(cfg_valid), 0);
      btn_apply = 1'b0; tick(); tick();
      check("s4_still_wait", 32'(cfg_valid), 0);
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      check("s4_offer_valid", 32'(cfg_valid), 1);
      check("s4_offer_mode", 32'(cfg_mode), 3);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("s4_hold_valid", 32'(cfg_valid), 1);
         check("s4_hold_active", 32'(active_mode), 0);
      end
      cfg_ready = 1'b1; tick(); cfg_ready = 1'b0;
      check("s4_active", 32'(active_mode), 3);
      check("s4_valid_done", 32'(cfg_valid), 0);
      check("s4_busy_done", 32'(busy), 0);
      check("s4_model_act", m_act, 3);

      // 5: latest apply wins over coincident frame_start
      btn_apply = 1'b1; tick();
      check("s5_same_ignored", 32'(busy), 0);
      btn_apply = 1'b0; tick();
      pulse_prev();
      btn_apply = 1'b1; tick(); btn_apply = 1'b0; tick();
      check("s5_first_latch", 32'(cfg_mode), 2);
      pulse_next(); pulse_next();
      check("s5_pend4", 32'(pending_mode), 4);
      btn_apply = 1'b1; frame_start = 1'b1; tick();
      btn_apply = 1'b0; frame_start = 1'b0;
      check("s5_relatch", 32'(cfg_mode), 4);
      check("s5_no_offer", 32'(cfg_valid), 0);
      tick(); tick();
      check("s5_still_no_offer", 32'(cfg_valid), 0);
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      check("s5_offer", 32'(cfg_valid), 1);
      pulse_next();
      check("s5_cfg_stable", 32'(cfg_mode), 4);
      cfg_ready = 1'b1; tick(); cfg_ready = 1'b0;
      check("s5_active4", 32'(active_mode), 4);
      pulse_prev();
      btn_apply = 1'b1; tick();
      check("s5_eq_ignored", 32'(busy), 0);
      btn_apply = 1'b0; tick();

      // 6: reset during offer
      pulse_prev();
      btn_apply = 1'b1; tick(); btn_apply = 1'b0;
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      check("s6_offer", 32'(cfg_valid), 1);
      reset = 1'b1; tick();
      check("s6_valid", 32'(cfg_valid), 0);
      check("s6_busy", 32'(busy), 0);
      check("s6_active", 32'(active_mode), 0);
      check("s6_pend", 32'(pending_mode), 0);
      reset = 1'b0; tick();
      check("s6_after_pend", 32'(pending_mode), 0);
      check("s6_after_cfg", 32'(cfg_mode), 0);

      // randomized phase
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 9) == 0)  btn_next  = ~btn_next;
         if ($urandom_range(0, 11) == 0) btn_prev  = ~btn_prev;
         if ($urandom_range(0, 5) == 0)  btn_apply = ~btn_apply;
         frame_start = ($urandom_range(0, 11) == 0);
         cfg_ready   = ($urandom_range(0, 2) == 0);
         reset       = ($urandom_range(0, 399) == 0);
         tick();
      end
      reset = 1'b0; btn_next = 1'b0; btn_prev = 1'b0; btn_apply = 1'b0;
      frame_start = 1'b0; cfg_ready = 1'b0;
      tick(); tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
